// File: rtl/reg_serializer.sv
// Captures a parallel word on a load handshake and shifts it out one bit per clock.
// Optional even-parity trailer bit enabled by defining REG_SERIALIZER_PARITY_EN.
module reg_serializer #(
   parameter int unsigned WIDTH     = 16,
   parameter bit          LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load,
   output logic             ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             done
);

   localparam int unsigned CW = $clog2(WIDTH);

`ifdef REG_SERIALIZER_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, DONE, PARITY} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
`ifdef REG_SERIALIZER_PARITY_EN
   logic             par_q, par_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
`ifdef REG_SERIALIZER_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
`ifdef REG_SERIALIZER_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      sreg_d     = sreg_q;
      cnt_d      = cnt_q;
`ifdef REG_SERIALIZER_PARITY_EN
      par_d      = par_q;
`endif
      ready      = 1'b0;
      sout       = 1'b0;
      sout_valid = 1'b0;
      done       = 1'b0;
      case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (load) begin
               sreg_d  = data_in;
               cnt_d   = '0;
`ifdef REG_SERIALIZER_PARITY_EN
               par_d   = ^data_in;
`endif
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sout_valid = 1'b1;
            sout       = LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1];
            sreg_d     = LSB_FIRST ? {1'b0, sreg_q[WIDTH-1:1]} : {sreg_q[WIDTH-2:0], 1'b0};
            // Counter holds on the last bit so it cannot wrap when WIDTH is a power of two.
            if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef REG_SERIALIZER_PARITY_EN
               state_d = PARITY;
`else
               state_d = DONE;
`endif
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`ifdef REG_SERIALIZER_PARITY_EN
         PARITY: begin
            sout_valid = 1'b1;
            sout       = par_q;
            state_d    = DONE;
         end
`endif
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_reg_serializer.sv
// Directed self-checking bench for reg_serializer; runs an LSB-first and an MSB-first
// instance side by side on shared stimulus.
module tb_reg_serializer;

`ifdef REG_SERIALIZER_PARITY_EN
   localparam int NB = 17;
`else
   localparam int NB = 16;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] data_in;
   logic        load;
   logic        a_ready, a_sout, a_valid, a_done;
   logic        b_ready, b_sout, b_valid, b_done;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int acc_prev = 0;
   int acc_last = 0;
   int acc_cnt = 0;

   always #5 clk = ~clk;

   reg_serializer #(.WIDTH(16), .LSB_FIRST(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load),
      .ready(a_ready), .sout(a_sout), .sout_valid(a_valid), .done(a_done)
   );

   reg_serializer #(.WIDTH(16), .LSB_FIRST(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load),
      .ready(b_ready), .sout(b_sout), .sout_valid(b_valid), .done(b_done)
   );

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst_n && load && a_ready) begin
         acc_prev = acc_last;
         acc_last = cyc;
         acc_cnt  = acc_cnt + 1;
      end
   end

   // Records sout over NB cycles starting right after the accepting edge.
   task automatic capture(input bit sel, output logic [16:0] seq, output int nvalid,
                          output logic done_seen);
      seq    = '0;
      nvalid = 0;
      for (int i = 0; i < NB; i++) begin
         if ((sel ? b_valid : a_valid) === 1'b1) nvalid++;
         seq[i] = sel ? b_sout : a_sout;
         @(posedge clk); #1;
      end
      done_seen = sel ? b_done : a_done;
   endtask

   function automatic logic [15:0] msb_word(input logic [16:0] seq);
      logic [15:0] w;
      for (int i = 0; i < 16; i++) w[15-i] = seq[i];
      return w;
   endfunction

   task automatic do_load(input logic [15:0] d);
      data_in = d;
      load    = 1'b1;
      @(posedge clk); #1;
      load    = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; load = 1'b0; data_in = '0;
      #2;
      tests++;
      if ({a_ready, a_sout, a_valid, a_done} !== 4'b1000) begin
         fails++; $display("FAIL reset_a: got %b want 1000", {a_ready, a_sout, a_valid, a_done});
      end
      tests++;
      if ({b_ready, b_sout, b_valid, b_done} !== 4'b1000) begin
         fails++; $display("FAIL reset_b: got %b want 1000", {b_ready, b_sout, b_valid, b_done});
      end
      @(posedge clk); #3; rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single;
      logic [16:0] seq; int nv; logic ds;
      do_load(16'h0001);
      tests++;
      if (a_ready !== 1'b0) begin fails++; $display("FAIL single_busy: ready=%b want 0", a_ready); end
      capture(1'b0, seq, nv, ds);
      tests++;
      if (seq[15:0] !== 16'h0001) begin fails++; $display("FAIL single_word: got %h want 0001", seq[15:0]); end
      tests++;
      if (nv != NB) begin fails++; $display("FAIL single_valid: got %0d want %0d", nv, NB); end
      tests++;
      if (ds !== 1'b1 || a_valid !== 1'b0 || a_ready !== 1'b0) begin
         fails++; $display("FAIL single_done: done=%b valid=%b ready=%b want 1 0 0", ds, a_valid, a_ready);
      end
      @(posedge clk); #1;
      tests++;
      if (a_ready !== 1'b1 || a_done !== 1'b0) begin
         fails++; $display("FAIL single_ready: ready=%b done=%b want 1 0", a_ready, a_done);
      end
   endtask

   task automatic test_back_to_back;
      logic [16:0] seq; int nv; logic ds;
      do_load(16'd13);
      capture(1'b0, seq, nv, ds);
      tests++;
      if (seq[15:0] !== 16'd13 || ds !== 1'b1) begin
         fails++; $display("FAIL b2b_first: got %h done=%b want 000d 1", seq[15:0], ds);
      end
      data_in = 16'd6; load = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      load = 1'b0;
      tests++;
      if (acc_last - acc_prev != NB + 2) begin
         fails++; $display("FAIL b2b_spacing: got %0d want %0d", acc_last - acc_prev, NB + 2);
      end
      capture(1'b0, seq, nv, ds);
      tests++;
      if (seq[15:0] !== 16'd6 || ds !== 1'b1) begin
         fails++; $display("FAIL b2b_second: got %h done=%b want 0006 1", seq[15:0], ds);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_msb_first;
      logic [16:0] seq; int nv; logic ds;
      do_load(16'h8001);
      capture(1'b1, seq, nv, ds);
      tests++;
      if (seq[0] !== 1'b1 || seq[15] !== 1'b1 || seq[14:1] !== 14'h0) begin
         fails++; $display("FAIL msb_bits: got %b want 1 then 0s then 1", seq[15:0]);
      end
      tests++;
      if (msb_word(seq) !== 16'h8001 || ds !== 1'b1 || nv != NB) begin
         fails++; $display("FAIL msb_word: got %h done=%b nv=%0d want 8001 1 %0d", msb_word(seq), ds, nv, NB);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_hold_load;
      logic [16:0] seq; int nv; logic ds; int c0;
      do_load(16'h00F0);
      c0 = acc_cnt;
      data_in = 16'hFFFF; load = 1'b1;
      capture(1'b0, seq, nv, ds);
      tests++;
      if (seq[15:0] !== 16'h00F0 || ds !== 1'b1) begin
         fails++; $display("FAIL hold_frame: got %h done=%b want 00f0 1", seq[15:0], ds);
      end
      tests++;
      if (acc_cnt != c0) begin fails++; $display("FAIL hold_ignored: accepts=%0d want %0d", acc_cnt, c0); end
      @(posedge clk); #1;
      @(posedge clk); #1;
      load = 1'b0;
      tests++;
      if (acc_last - acc_prev != NB + 2) begin
         fails++; $display("FAIL hold_spacing: got %0d want %0d", acc_last - acc_prev, NB + 2);
      end
      capture(1'b0, seq, nv, ds);
      tests++;
      if (seq[15:0] !== 16'hFFFF || ds !== 1'b1) begin
         fails++; $display("FAIL hold_second: got %h done=%b want ffff 1", seq[15:0], ds);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_async_reset;
      logic [16:0] seq; int nv; logic ds; logic saw_done;
      do_load(16'hAAAA);
      for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
      #2; rst_n = 1'b0; #1;
      tests++;
      if ({a_ready, a_sout, a_valid, a_done} !== 4'b1000) begin
         fails++; $display("FAIL areset_out: got %b want 1000", {a_ready, a_sout, a_valid, a_done});
      end
      @(posedge clk); #3; rst_n = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < NB + 4; i++) begin
         @(posedge clk); #1;
         if (a_done === 1'b1 || a_valid === 1'b1) saw_done = 1'b1;
      end
      tests++;
      if (saw_done !== 1'b0) begin fails++; $display("FAIL areset_drop: activity=%b want 0", saw_done); end
      do_load(16'h0003);
      capture(1'b0, seq, nv, ds);
      tests++;
      if (seq[15:0] !== 16'h0003 || ds !== 1'b1 || nv != NB) begin
         fails++; $display("FAIL areset_next: got %h done=%b nv=%0d want 0003 1 %0d", seq[15:0], ds, nv, NB);
      end
      @(posedge clk); #1;
   endtask

`ifdef REG_SERIALIZER_PARITY_EN
   task automatic test_parity;
      logic [16:0] seq; int nv; logic ds;
      logic [15:0] words [3];
      logic        pbit  [3];
      words[0] = 16'd13;    pbit[0] = 1'b1;
      words[1] = 16'd6;     pbit[1] = 1'b0;
      words[2] = 16'hFFFF;  pbit[2] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         do_load(words[k]);
         capture(1'b0, seq, nv, ds);
         tests++;
         if (seq[16] !== pbit[k] || seq[15:0] !== words[k] || ds !== 1'b1 || nv != 17) begin
            fails++;
            $display("FAIL parity_%0d: par=%b word=%h done=%b nv=%0d want %b %h 1 17",
                     k, seq[16], seq[15:0], ds, nv, pbit[k], words[k]);
         end
         @(posedge clk); #1;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_msb_first();
      test_hold_load();
      test_async_reset();
`ifdef REG_SERIALIZER_PARITY_EN
      test_parity();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/reg_serializer.md
Name: reg_serializer

Overview:
Reader side of the 16-bit behavioural register. Captures a parallel register value (typically a register's `out`) on a load handshake and shifts it out serially, one bit per clock, with a valid strobe and an end-of-frame pulse. Sits between a `register` instance and a serial link or monitor. A new word is accepted only when the block is idle.

Parameters:
WIDTH, 16, data word width in bits; must be >= 2
LSB_FIRST, 1, 1 = shift out bit 0 first; 0 = shift out bit WIDTH-1 first

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
data_in  input  WIDTH  parallel word to serialize; sampled only when a load is accepted
load  input  1  load request; accepted when load=1 and ready=1 at a rising edge
ready  output  1  high only in IDLE; block can accept a load
sout  output  1  current serial bit; 0 whenever sout_valid=0
sout_valid  output  1  high during every cycle in which sout carries a frame bit
done  output  1  one-cycle pulse after the last frame bit

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-frame): state=IDLE, shift register=0, bit counter=0, ready=1, sout=0, sout_valid=0, done=0. Any frame in progress is dropped; no done pulse.
- States: IDLE, SHIFT, DONE (PARITY is added when the optional feature is compiled in).
- IDLE: ready=1, sout_valid=0, done=0. On an edge with load=1: capture data_in into the shift register, set counter=0, go to SHIFT. With load=0: stay in IDLE.
- SHIFT: ready=0, sout_valid=1, sout=sreg[0] if LSB_FIRST=1, else sreg[WIDTH-1]. Each edge shifts by one (right for LSB_FIRST, left otherwise; zero fill) and increments the counter.
- SHIFT exit: on the edge where counter==WIDTH-1, go to DONE, or to PARITY if PARITY_EN is defined.
- DONE: exactly one cycle; done=1, sout_valid=0, sout=0, ready=0. Next edge goes to IDLE.
- Latency: load accepted at edge N. Bit 0 of the frame is valid in the cycle after edge N. Bits are emitted on consecutive cycles with no gaps. done follows WIDTH cycles later. ready is high again in the cycle after done. The minimum spacing between accepted loads is WIDTH+2 cycles (WIDTH+3 with parity).
- load while ready=0 (SHIFT, PARITY, DONE): ignored and not queued. data_in changes while not in IDLE have no effect on the frame.
- Counter width is $clog2(WIDTH). The counter never wraps within a frame and is reset to 0 on every load.

Optional Feature:
- Macro: REG_SERIALIZER_PARITY_EN.
- Defined: an even-parity bit is appended after the data bits. The data's XOR is computed from data_in at load time and held in a register. PARITY state lasts one cycle with sout_valid=1 and sout equal to the parity bit, then goes to DONE. The frame is WIDTH+1 bits.
- Not defined: no PARITY state and no parity register; the frame is exactly WIDTH bits.

Test Plan:
- Reset, then load data_in=16'h0001 with LSB_FIRST=1 -> sout_valid high for 16 cycles; sout = 1 then fifteen 0s; done high for 1 cycle; ready returns 1 on the following cycle.
- Load 16'd13 (LSB_FIRST=1) -> sout sequence 1,0,1,1 followed by twelve 0s. Immediately reload 16'd6 when ready=1 -> 0,1,1 followed by thirteen 0s. Spacing between the two accepted loads is 18 cycles.
- LSB_FIRST=0, load 16'h8001 -> first sout=1, next fourteen 0s, last sout=1.
- Load 16'h00F0, then hold load=1 with data_in=16'hFFFF throughout the frame and the done cycle -> the emitted frame is exactly 16'h00F0; the second word is accepted only in the IDLE cycle after done.
- Load 16'hAAAA, deassert rst_n asynchronously (between edges) after 5 bits -> sout, sout_valid and done go to 0 immediately and ready=1; no done pulse occurs; the next load 16'h0003 serializes cleanly.
- With REG_SERIALIZER_PARITY_EN: 16'd13 -> 17th bit=1; 16'd6 -> 17th bit=0; 16'hFFFF -> 17th bit=0; done one cycle after the parity bit.
